// File: rtl/dmt_preamble_pkg.sv
// Shared definitions for the DMT training preamble generator: FSM state
// encoding, ROM table select, default geometry and the ROM table contents.
package dmt_preamble_pkg;

    // Default preamble geometry
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_STS_LEN    = 16;
    localparam int DEF_LTS_LEN    = 128;
    localparam int DEF_LTS_CP_LEN = 32;
    localparam int DEF_LTS_REPS   = 2;

    // Native width of the stored table words
    localparam int ROM_W = 16;

    // Names of the memory images holding the same tables that sts_word and
    // lts_word below generate; kept here so the exported images and the
    // synthesizable tables are named in one place.
    localparam string STS_ROM_FILE = "dmt_sts_rom.hex";
    localparam string LTS_ROM_FILE = "dmt_lts_rom.hex";

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STS      = 3'd1,
        ST_LTS_CP   = 3'd2,
        ST_LTS_BODY = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef enum logic {
        ROM_STS = 1'b0,
        ROM_LTS = 1'b1
    } rom_sel_e;

    // Index width for a counter covering 0..n-1, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // STS table word: fixed upper byte, ramp of 17 per index in the low byte
    function automatic logic [ROM_W-1:0] sts_word(input logic [31:0] idx);
        logic [7:0] ramp;
        ramp = 8'(idx * 32'd17);
        return {8'h5A, ramp};
    endfunction

    // LTS table word: fixed upper nibble, index times 37 modulo 4096 below it
    function automatic logic [ROM_W-1:0] lts_word(input logic [31:0] idx);
        logic [11:0] ramp;
        ramp = 12'(idx * 32'd37);
        return {4'hC, ramp};
    endfunction

endpackage

// File: rtl/dmt_preamble_rom.sv
// Dual-table synchronous ROM: one registered read per cycle from either the
// STS table or the LTS table, selected by sel.
module dmt_preamble_rom
    import dmt_preamble_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 7
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST_N,
    input  rom_sel_e                 sel,
    input  logic [ADDR_W-1:0]        addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic [ROM_W-1:0] word;

    // Table lookup for the addressed word
    always_comb begin
        word = '0;
        if (sel == ROM_LTS) begin
            word = lts_word(32'(addr));
        end else begin
            word = sts_word(32'(addr));
        end
    end

    // Registered read port
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            rd_data <= '0;
        end else begin
            rd_data <= DATA_W'(signed'(word));
        end
    end

endmodule

// File: rtl/dmt_preamble_gen.sv
// DMT training preamble generator. SHORT_ACK and LONG_ACK are level enables
// from the MCU: SHORT_ACK opens the STS window, LONG_ACK opens the LTS window
// and wins whenever both are high. A sample is emitted for every FSM cycle
// spent inside an open window; it reaches SAMPLE_OUT one cycle later through
// the registered ROM read, qualified by SAMPLE_VALID.
module dmt_preamble_gen
    import dmt_preamble_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STS_LEN    = DEF_STS_LEN,
    parameter int LTS_LEN    = DEF_LTS_LEN,
    parameter int LTS_CP_LEN = DEF_LTS_CP_LEN,
    parameter int LTS_REPS   = DEF_LTS_REPS
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST_N,
    input  logic                     PHY_RST,
    input  logic                     SHORT_ACK,
    input  logic                     LONG_ACK,
    output logic signed [DATA_W-1:0] SAMPLE_OUT,
    output logic                     SAMPLE_VALID,
    output logic                     PREAMBLE_DONE,
    output logic                     PREAMBLE_ERR,
    output state_e                   dbg_state
);

    localparam int STS_AW = idx_width(STS_LEN);
    localparam int CP_AW  = idx_width(LTS_CP_LEN);
    localparam int LTS_AW = idx_width(LTS_LEN);
    localparam int REP_W  = idx_width(LTS_REPS);
    localparam int ROM_AW = (LTS_AW > STS_AW) ? LTS_AW : STS_AW;

    localparam logic [STS_AW-1:0] STS_LAST = STS_AW'(STS_LEN - 1);
    localparam logic [CP_AW-1:0]  CP_LAST  = CP_AW'(LTS_CP_LEN - 1);
    localparam logic [LTS_AW-1:0] LTS_LAST = LTS_AW'(LTS_LEN - 1);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'(LTS_REPS - 1);
    // The cyclic prefix replays the tail of the LTS body
    localparam logic [ROM_AW-1:0] CP_BASE  = ROM_AW'(LTS_LEN - LTS_CP_LEN);

    state_e              state_q, state_d;
    logic [STS_AW-1:0]   sts_idx_q, sts_idx_d;
    logic [CP_AW-1:0]    cp_idx_q, cp_idx_d;
    logic [LTS_AW-1:0]   lts_idx_q, lts_idx_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                armed_q, armed_d;

    logic                emit;
    logic                set_err;
    rom_sel_e            rom_sel;
    logic [ROM_AW-1:0]   rom_addr;
    logic signed [DATA_W-1:0] rom_data;

    logic                valid_q;
    logic                done_q;
    logic                err_q;

    // State register, index counters and the retrigger guard
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q   <= ST_IDLE;
            sts_idx_q <= '0;
            cp_idx_q  <= '0;
            lts_idx_q <= '0;
            rep_q     <= '0;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            sts_idx_q <= sts_idx_d;
            cp_idx_q  <= cp_idx_d;
            lts_idx_q <= lts_idx_d;
            rep_q     <= rep_d;
            armed_q   <= armed_d;
        end
    end

    // Next state, index updates and the ROM address for this cycle's sample
    always_comb begin
        state_d   = state_q;
        sts_idx_d = sts_idx_q;
        cp_idx_d  = cp_idx_q;
        lts_idx_d = lts_idx_q;
        rep_d     = rep_q;
        armed_d   = armed_q;
        emit      = 1'b0;
        set_err   = 1'b0;
        rom_sel   = ROM_STS;
        rom_addr  = '0;

        // Both ACKs low re-arms; leaving IDLE below disarms
        if (!SHORT_ACK && !LONG_ACK) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sts_idx_d = '0;
                cp_idx_d  = '0;
                lts_idx_d = '0;
                rep_d     = '0;
                if (armed_q) begin
                    if (LONG_ACK) begin
                        state_d = ST_LTS_CP;
                        armed_d = 1'b0;
                    end else if (SHORT_ACK) begin
                        state_d = ST_STS;
                        armed_d = 1'b0;
                    end
                end
            end

            ST_STS: begin
                rom_sel  = ROM_STS;
                rom_addr = ROM_AW'(sts_idx_q);
                if (LONG_ACK) begin
                    // STS period is cut short wherever it happens to be
                    emit      = 1'b1;
                    state_d   = ST_LTS_CP;
                    sts_idx_d = '0;
                    cp_idx_d  = '0;
                end else if (SHORT_ACK) begin
                    emit      = 1'b1;
                    sts_idx_d = (sts_idx_q == STS_LAST) ? '0 : sts_idx_q + STS_AW'(1);
                end else begin
                    state_d   = ST_IDLE;
                    sts_idx_d = '0;
                end
            end

            ST_LTS_CP: begin
                rom_sel  = ROM_LTS;
                rom_addr = CP_BASE + ROM_AW'(cp_idx_q);
                if (!LONG_ACK) begin
                    set_err  = 1'b1;
                    state_d  = ST_IDLE;
                    cp_idx_d = '0;
                end else begin
                    emit = 1'b1;
                    if (cp_idx_q == CP_LAST) begin
                        state_d   = ST_LTS_BODY;
                        cp_idx_d  = '0;
                        lts_idx_d = '0;
                        rep_d     = '0;
                    end else begin
                        cp_idx_d = cp_idx_q + CP_AW'(1);
                    end
                end
            end

            ST_LTS_BODY: begin
                rom_sel  = ROM_LTS;
                rom_addr = ROM_AW'(lts_idx_q);
                if (!LONG_ACK) begin
                    set_err   = 1'b1;
                    state_d   = ST_IDLE;
                    lts_idx_d = '0;
                    rep_d     = '0;
                end else begin
                    emit = 1'b1;
                    if (lts_idx_q == LTS_LAST) begin
                        lts_idx_d = '0;
                        if (rep_q == REP_LAST) begin
                            state_d = ST_DONE;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end else begin
                        lts_idx_d = lts_idx_q + LTS_AW'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // MCU clear behaves exactly like a reset of the FSM and counters
        if (PHY_RST) begin
            state_d   = ST_IDLE;
            sts_idx_d = '0;
            cp_idx_d  = '0;
            lts_idx_d = '0;
            rep_d     = '0;
            armed_d   = 1'b1;
        end
    end

    dmt_preamble_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ROM_AW)
    ) u_rom (
        .SYS_CLK   (SYS_CLK),
        .SYS_RST_N (SYS_RST_N),
        .sel       (rom_sel),
        .addr      (rom_addr),
        .rd_data   (rom_data)
    );

    // Output flags, aligned with the ROM read stage
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= emit && !PHY_RST;
            done_q  <= (state_q == ST_DONE) && !PHY_RST;
            err_q   <= !PHY_RST && (err_q || set_err);
        end
    end

    // Sample is forced to zero whenever it is not a preamble sample
    assign SAMPLE_OUT    = valid_q ? rom_data : '0;
    assign SAMPLE_VALID  = valid_q;
    assign PREAMBLE_DONE = done_q;
    assign PREAMBLE_ERR  = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmt_preamble_gen.sv
// Directed bench for dmt_preamble_gen: nominal MCU sequence, ACK overlap,
// early LONG_ACK drop, PHY_RST abort/restart, LONG_ACK tail and async reset.
module tb_dmt_preamble_gen;
    import dmt_preamble_pkg::*;

    localparam int MEM_D = 1024;

    logic               SYS_CLK;
    logic               SYS_RST_N;
    logic               PHY_RST;
    logic               SHORT_ACK;
    logic               LONG_ACK;
    logic signed [15:0] SAMPLE_OUT;
    logic               SAMPLE_VALID;
    logic               PREAMBLE_DONE;
    logic               PREAMBLE_ERR;
    state_e             dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    bit          sb_on;
    int          cyc;
    int          valid_cnt;
    int          done_cnt;
    int          first_valid_cyc;
    int          last_valid_cyc;
    int          done_cyc;

    logic [15:0] s_mem [MEM_D];
    logic        v_mem [MEM_D];
    logic        e_mem [MEM_D];
    state_e      st_mem[MEM_D];

    dmt_preamble_gen dut (
        .SYS_CLK       (SYS_CLK),
        .SYS_RST_N     (SYS_RST_N),
        .PHY_RST       (PHY_RST),
        .SHORT_ACK     (SHORT_ACK),
        .LONG_ACK      (LONG_ACK),
        .SAMPLE_OUT    (SAMPLE_OUT),
        .SAMPLE_VALID  (SAMPLE_VALID),
        .PREAMBLE_DONE (PREAMBLE_DONE),
        .PREAMBLE_ERR  (PREAMBLE_ERR),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_sts(input int i);
        return 16'h5A00 + 16'((i % 16) * 17);
    endfunction

    function automatic logic [15:0] exp_lts(input int i);
        return 16'hC000 + 16'((i * 37) % 4096);
    endfunction

    task automatic push_sts(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_sts(i));
    endtask

    task automatic push_lts(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_lts((first + i) % 128));
    endtask

    task automatic clear_stats();
        cyc             = 0;
        valid_cnt       = 0;
        done_cnt        = 0;
        first_valid_cyc = -1;
        last_valid_cyc  = -1;
        done_cyc        = -1;
        exp_q.delete();
    endtask

    // One clock: sample outputs 1 unit after the edge, feed the scoreboard
    task automatic cycle();
        @(posedge SYS_CLK);
        #1;
        cyc++;
        if (cyc < MEM_D) begin
            s_mem[cyc]  = SAMPLE_OUT;
            v_mem[cyc]  = SAMPLE_VALID;
            e_mem[cyc]  = PREAMBLE_ERR;
            st_mem[cyc] = dbg_state;
        end
        if (SAMPLE_VALID) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (sb_on) begin
                if (exp_q.size() == 0) check("extra_sample", {16'h0, SAMPLE_OUT}, 32'hFFFF_FFFF);
                else check("sample", {16'h0, SAMPLE_OUT}, {16'h0, exp_q.pop_front()});
            end
        end else if (sb_on) begin
            check("idle_zero", {16'h0, SAMPLE_OUT}, 32'h0);
        end
        if (PREAMBLE_DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Drive ACK windows [lo,hi) and an optional PHY_RST cycle, then go quiet
    task automatic run_pattern(input int n, input int sa_lo, input int sa_hi,
                               input int la_lo, input int la_hi, input int phy_at);
        for (int c = 0; c < n; c++) begin
            SHORT_ACK = (c >= sa_lo) && (c < sa_hi);
            LONG_ACK  = (c >= la_lo) && (c < la_hi);
            PHY_RST   = (c == phy_at);
            cycle();
        end
        SHORT_ACK = 1'b0;
        LONG_ACK  = 1'b0;
        PHY_RST   = 1'b0;
    endtask

    task automatic idle(input int n);
        run_pattern(n, 0, 0, 0, 0, -1);
    endtask

    initial begin
        SYS_RST_N = 1'b0;
        PHY_RST   = 1'b0;
        SHORT_ACK = 1'b0;
        LONG_ACK  = 1'b0;
        sb_on     = 1'b0;
        clear_stats();

        // Reset state
        repeat (3) @(posedge SYS_CLK);
        #1;
        check("rst_out", {16'h0, SAMPLE_OUT}, 32'h0);
        check("rst_valid", SAMPLE_VALID, 0);
        check("rst_done", PREAMBLE_DONE, 0);
        check("rst_err", PREAMBLE_ERR, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        #2;
        SYS_RST_N = 1'b1;
        idle(4);

        // Nominal MCU sequence, overlap lands at sts_idx 14
        clear_stats();
        sb_on = 1'b1;
        push_sts(319);
        push_lts(96, 32);
        push_lts(0, 256);
        run_pattern(620, 0, 320, 319, 609, -1);
        check("nom_count", valid_cnt, 607);
        check("nom_queue_empty", exp_q.size(), 0);
        check("nom_first_valid", first_valid_cyc, 2);
        check("nom_last_valid", last_valid_cyc, 608);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_done_cyc", done_cyc, 609);
        check("nom_err", PREAMBLE_ERR, 0);
        check("nom_sts0", s_mem[2], 32'h5A00);
        check("nom_sts15", s_mem[17], 32'h5AFF);
        check("nom_sts_wrap", s_mem[18], 32'h5A00);
        check("nom_last_sts", s_mem[320], 32'h5AEE);
        check("nom_first_cp", s_mem[321], 32'hCDE0);
        check("nom_last_cp", s_mem[352], 32'hC25B);
        check("nom_first_body", s_mem[353], 32'hC000);
        check("nom_last_body", s_mem[608], 32'hC25B);
        check("nom_valid_after", v_mem[609], 0);
        idle(5);

        // Overlap at sts_idx 6, then LONG_ACK dropped after 100 LTS samples
        clear_stats();
        push_sts(7);
        push_lts(96, 32);
        push_lts(0, 68);
        run_pattern(130, 0, 8, 7, 108, -1);
        check("drop_overlap_sts", s_mem[8], 32'h5A66);
        check("drop_overlap_lts", s_mem[9], 32'hCDE0);
        check("drop_valid_last", v_mem[108], 1);
        check("drop_valid_low", v_mem[109], 0);
        check("drop_err_before", e_mem[108], 0);
        check("drop_err_set", e_mem[109], 1);
        check("drop_err_held", e_mem[129], 1);
        check("drop_state", 32'(st_mem[109]), 32'(ST_IDLE));
        check("drop_count", valid_cnt, 107);
        check("drop_queue_empty", exp_q.size(), 0);
        check("drop_no_done", done_cnt, 0);
        idle(5);

        // PHY_RST at STS sample 50, then restart after both ACKs low
        clear_stats();
        push_sts(50);
        push_sts(4);
        run_pattern(55, 0, 52, 0, 0, 51);
        run_pattern(10, 0, 5, 0, 0, -1);
        check("phy_valid_before", v_mem[51], 1);
        check("phy_err_before", e_mem[51], 1);
        check("phy_valid_after", v_mem[52], 0);
        check("phy_out_after", {16'h0, s_mem[52]}, 32'h0);
        check("phy_err_clear", e_mem[52], 0);
        check("phy_state", 32'(st_mem[52]), 32'(ST_IDLE));
        check("phy_gap", v_mem[56], 0);
        check("phy_restart", s_mem[57], 32'h5A00);
        check("phy_count", valid_cnt, 54);
        check("phy_queue_empty", exp_q.size(), 0);
        idle(5);

        // LTS straight from IDLE, LONG_ACK held 10 cycles past DONE
        clear_stats();
        push_lts(96, 32);
        push_lts(0, 256);
        run_pattern(320, 0, 0, 0, 300, -1);
        check("tail_first", s_mem[2], 32'hCDE0);
        check("tail_last_valid", last_valid_cyc, 289);
        check("tail_done_cyc", done_cyc, 290);
        check("tail_done_cnt", done_cnt, 1);
        check("tail_count", valid_cnt, 288);
        check("tail_state", 32'(st_mem[295]), 32'(ST_IDLE));
        check("tail_no_retrigger", v_mem[295], 0);
        check("tail_queue_empty", exp_q.size(), 0);
        check("tail_err", PREAMBLE_ERR, 0);
        idle(5);

        // Async reset mid-LTS with PREAMBLE_ERR set beforehand
        sb_on = 1'b0;
        clear_stats();
        run_pattern(60, 0, 0, 0, 50, -1);
        check("arst_err_setup", e_mem[51], 1);
        run_pattern(40, 0, 0, 0, 40, -1);
        check("arst_valid_before", SAMPLE_VALID, 1);
        check("arst_err_before", PREAMBLE_ERR, 1);
        #3;
        SYS_RST_N = 1'b0;
        #1;
        check("arst_valid", SAMPLE_VALID, 0);
        check("arst_out", {16'h0, SAMPLE_OUT}, 32'h0);
        check("arst_err", PREAMBLE_ERR, 0);
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        #10;
        SYS_RST_N = 1'b1;
        idle(5);
        check("arst_post_valid", SAMPLE_VALID, 0);
        check("arst_post_state", 32'(dbg_state), 32'(ST_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
